// File: rtl/rei_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rei_pkg
//  Description : Shared types and constants for the integer divide unit
//  Revision    : 1.0  initial release
// ============================================================================
package rei_pkg;

    localparam int XLEN      = 64;
    localparam int DIV_ITERS = 64;
    localparam int DIV_CNT_W = 7;

    // Operation qualifiers supplied with each divide request
    typedef struct packed {
        logic is_signed;
        logic is_rem;
        logic is_word;
    } div_ctrl_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Select 32- or 64-bit operand; 32-bit values are sign- or zero-extended
    function automatic logic [XLEN-1:0] ext_operand(
        input logic [XLEN-1:0] v,
        input logic            is_word,
        input logic            is_signed
    );
        logic [XLEN-1:0] r;
        if (is_word)
            r = {{(XLEN-32){is_signed & v[31]}}, v[31:0]};
        else
            r = v;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative radix-2 restoring integer divider (64-bit and
//                word forms, signed/unsigned, quotient/remainder)
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit
    import rei_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  div_ctrl_s       div_ctrl_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] rslt_o
);

    localparam logic [DIV_CNT_W-1:0] c_last_iter = DIV_CNT_W'(DIV_ITERS - 1);

    div_state_e            r_state;
    div_state_e            w_state_nxt;
    logic [DIV_CNT_W-1:0]  r_cnt;

    // r_dvd starts as the dividend magnitude and shifts into the quotient
    logic [XLEN-1:0]       r_dvd;
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_dsr;
    logic                  r_q_neg;
    logic                  r_r_neg;
    logic                  r_is_rem;
    logic                  r_is_word;

    logic                  w_accept;
    logic [XLEN-1:0]       w_a;
    logic [XLEN-1:0]       w_b;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [XLEN-1:0]       w_a_mag;
    logic [XLEN-1:0]       w_b_mag;
    logic                  w_b_zero;
    logic [XLEN:0]         w_shift;
    logic [XLEN:0]         w_diff;
    logic [XLEN-1:0]       w_q_fix;
    logic [XLEN-1:0]       w_r_fix;
    logic [XLEN-1:0]       w_sel;

    assign w_accept = valid_i && (r_state == IDLE) && !flush_i;

    assign w_a      = ext_operand(src1_i, div_ctrl_i.is_word, div_ctrl_i.is_signed);
    assign w_b      = ext_operand(src2_i, div_ctrl_i.is_word, div_ctrl_i.is_signed);
    assign w_a_neg  = div_ctrl_i.is_signed & w_a[XLEN-1];
    assign w_b_neg  = div_ctrl_i.is_signed & w_b[XLEN-1];
    // Two's-complement negation maps -2^63 onto 2^63 when read as unsigned
    assign w_a_mag  = w_a_neg ? (~w_a + 1'b1) : w_a;
    assign w_b_mag  = w_b_neg ? (~w_b + 1'b1) : w_b;
    assign w_b_zero = (w_b == '0);

    // Partial remainder stays below the divisor, so the top shift bit is 0
    // and bit XLEN of the difference is the borrow
    assign w_shift  = {r_rem, r_dvd[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, r_dsr};

    assign w_q_fix  = r_q_neg ? (~r_dvd + 1'b1) : r_dvd;
    assign w_r_fix  = r_r_neg ? (~r_rem + 1'b1) : r_rem;
    assign w_sel    = r_is_rem ? w_r_fix : w_q_fix;

    assign ready_o  = (r_state == IDLE);
    assign valid_o  = (r_state == DONE);
    assign rslt_o   = (r_state != DONE) ? '0 :
                      r_is_word ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_nxt = w_b_zero ? DONE : CALC;
            end
            CALC: begin
                if (r_cnt == c_last_iter)
                    w_state_nxt = DONE;
            end
            DONE: begin
                if (ready_i)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush_i)
            w_state_nxt = IDLE;
    end

    // Operand capture on accept and one restoring iteration per CALC cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_dsr     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_is_word <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_dsr     <= w_b_mag;
            r_is_rem  <= div_ctrl_i.is_rem;
            r_is_word <= div_ctrl_i.is_word;
            if (w_b_zero) begin
                // Divide by zero: raw all-ones quotient, dividend as remainder
                r_dvd   <= '1;
                r_rem   <= w_a;
                r_q_neg <= 1'b0;
                r_r_neg <= 1'b0;
            end else begin
                r_dvd   <= w_a_mag;
                r_rem   <= '0;
                r_q_neg <= w_a_neg ^ w_b_neg;
                r_r_neg <= w_a_neg;
            end
        end else if ((r_state == CALC) && !flush_i) begin
            r_cnt <= r_cnt + 1'b1;
            r_dvd <= {r_dvd[XLEN-2:0], ~w_diff[XLEN]};
            r_rem <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
        end
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters SHALL be none; XLEN (64) SHALL come from rei_pkg.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 flush_i  input  1  synchronous abort of any in-flight operation.
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  unit can accept a request.
REQ-007 div_ctrl_i  input  div_ctrl_s  fields is_signed, is_rem, is_word.
REQ-008 src1_i  input  XLEN  dividend.
REQ-009 src2_i  input  XLEN  divisor.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts result.
REQ-012 rslt_o  output  XLEN  quotient or remainder.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 ready_o SHALL be 1 only in IDLE; valid_o SHALL be 1 only in DONE.
REQ-015 A request SHALL be accepted on an edge where valid_i && ready_o; valid_i outside IDLE SHALL be ignored.
REQ-016 On acceptance, operands SHALL be taken from [31:0] when is_word, sign-extended if is_signed, else zero-extended; otherwise the full 64 bits are used.
REQ-017 On acceptance, operand magnitudes (negated if is_signed and negative) and the quotient and remainder sign flags SHALL be registered; the 64-bit magnitude of -2^63 SHALL be 2^63.
REQ-018 The quotient sign SHALL be src1 sign XOR src2 sign; the remainder sign SHALL be the src1 sign.
REQ-019 With a nonzero divisor, IDLE SHALL go to CALC with the iteration counter at 0.
REQ-020 CALC SHALL perform one radix-2 restoring iteration per cycle for exactly 64 cycles, then enter DONE; valid_o SHALL rise 64 clocks after the accept edge.
REQ-021 A zero divisor SHALL go IDLE->DONE directly, valid_o one clock after accept; quotient all ones, remainder equal to the extended dividend.
REQ-022 In DONE, rslt_o SHALL be the sign-corrected quotient or remainder (per is_rem); when is_word, it SHALL be bits [31:0] sign-extended from bit 31.
REQ-023 Signed overflow (-2^63 / -1, or the word equivalent) SHALL require no special path: quotient = dividend, remainder = 0.
REQ-024 rslt_o SHALL hold stable in DONE until valid_o && ready_i, then return to IDLE; ready_o SHALL not be asserted in that same cycle.
REQ-025 flush_i SHALL force IDLE on the next edge from any state, discarding the operation; rst_i SHALL take priority over flush_i.
REQ-026 flush_i coincident with an accept SHALL discard the request.

Reset
REQ-027 On rst_i: state IDLE, counter 0, all datapath registers 0; ready_o=1, valid_o=0, rslt_o=0 from the next cycle.
REQ-028 rst_i asserted mid-CALC or in DONE SHALL abort without emitting valid_o.

Structure
REQ-029 div_ctrl_s, the div_state_e enum and DIV_ITERS (64) SHALL be in rei_pkg.
REQ-030 The design SHALL be a single module with no sub-module, using one 65-bit subtractor and a 7-bit counter.

Verification
REQ-031 DIV 20 / -3 -> rslt_o 0xFFFF_FFFF_FFFF_FFFA with valid_o 64 clocks after accept; REM, same operands -> 2.
REQ-032 DIVU 0x1234 / 0 -> 0xFFFF_FFFF_FFFF_FFFF one clock after accept; REMU, same operands -> 0x1234.
REQ-033 DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM, same operands -> 0.
REQ-034 Word ops:
- DIVW 0x1_0000_0007 / 2 -> 3.
- DIVUW 0xFFFF_FFFF / 1 -> 0xFFFF_FFFF_FFFF_FFFF.
- REMUW 0xFFFF_FFFF / 0x10 -> 0xF.
REQ-035 ready_i held low 10 cycles in DONE -> rslt_o and valid_o stable, ready_o=0, valid_i pulses ignored; ready_i=1 -> IDLE next cycle.
REQ-036 flush_i at CALC cycle 30 -> ready_o=1 next cycle, valid_o never asserted; a following DIVU 100 / 7 -> 14.
